led_pwm_driver: RTL



---
 rtl/led_pwm_driver.sv | 88 ++++++++
 1 files changed

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: per-byte-group 4-bit PWM brightness and blinking on the LED pad drive.
// Define LED_READBACK_EN to add the combinational cfgrdata config readback port.
module led_pwm_driver #(
  parameter int PRESCALE   = 100,
  parameter int FRAME_BITS = 7
) (
  input  logic        led_clk,
  input  logic        ledrst,
  input  logic [23:0] ledin,
  input  logic        cfgcs,
  input  logic        cfgwrite,
  input  logic [1:0]  cfgaddr,
  input  logic [15:0] cfgwdata,
  output logic [23:0] led_pad,
  output logic        frame_done
`ifdef LED_READBACK_EN
  ,
  output logic [15:0] cfgrdata
`endif
);
  logic [15:0]           pre_q, pre_d;
  logic [3:0]            pwm_q, pwm_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [11:0]           bright_q;
  logic [2:0]            blink_en_q;
  logic [1:0]            blink_sel_q;
  logic [23:0]           led_pad_q, led_pad_d;
  logic                  frame_done_q;
  logic                  tick, wrap, wr, phase;
  logic [3:0]            phase_cand;
  logic [2:0]            lit;
  assign tick    = pre_q == 16'(PRESCALE - 1);
  assign wrap    = tick && pwm_q == 4'hF;
  assign wr      = cfgcs && cfgwrite;
  assign pre_d   = tick ? 16'd0 : pre_q + 16'd1;
  assign pwm_d   = tick ? pwm_q + 4'd1 : pwm_q;
  assign frame_d = wrap ? frame_q + FRAME_BITS'(1) : frame_q;
  // Blink phase bit 3+sel, clamped to the frame counter MSB for narrow counters.
  genvar s;
  for (s = 0; s < 4; s++) begin : g_phase
    assign phase_cand[s] = frame_q[(3 + s) >= FRAME_BITS ? FRAME_BITS - 1 : 3 + s];
  end
  assign phase = phase_cand[blink_sel_q];
  genvar g;
  for (g = 0; g < 3; g++) begin : g_grp
    logic [3:0] b;
    assign b = bright_q[4*g +: 4];
    assign lit[g] = !(blink_en_q[g] && phase) && (b == 4'hF || pwm_q < b);
    assign led_pad_d[8*g +: 8] = ledin[8*g +: 8] & {8{lit[g]}};
  end
  always_ff @(posedge led_clk or posedge ledrst) begin
    if (ledrst) begin
      pre_q        <= '0;
      pwm_q        <= '0;
      frame_q      <= '0;
      bright_q     <= 12'hFFF;
      blink_en_q   <= '0;
      blink_sel_q  <= '0;
      led_pad_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      pwm_q        <= pwm_d;
      frame_q      <= frame_d;
      led_pad_q    <= led_pad_d;
      frame_done_q <= wrap;
      if (wr && cfgaddr == 2'd0) bright_q <= cfgwdata[11:0];
      if (wr && cfgaddr == 2'd1) begin
        blink_en_q  <= cfgwdata[2:0];
        blink_sel_q <= cfgwdata[5:4];
      end
    end
  end
  assign led_pad    = led_pad_q;
  assign frame_done = frame_done_q;
`ifdef LED_READBACK_EN
  logic [6:0] frame7;
  if (FRAME_BITS >= 7) begin : g_trunc
    assign frame7 = frame_q[6:0];
  end else begin : g_zext
    assign frame7 = {{(7 - FRAME_BITS){1'b0}}, frame_q};
  end
  assign cfgrdata = !cfgcs            ? 16'h0 :
                    cfgaddr == 2'd0   ? {4'h0, bright_q} :
                    cfgaddr == 2'd1   ? {10'h0, blink_sel_q, 1'b0, blink_en_q} :
                    cfgaddr == 2'd2   ? {9'h0, frame7} : 16'h0;
`endif
endmodule
